// File: rtl/lcd_ghost_blend.sv
// LCD ghosting emulation: each pixel is averaged with the same pixel of the previous frame.
// A 160x144 store keeps the previous frame's raw pixels. The pipeline is fixed at two stages.
module lcd_ghost_blend (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkena,
    input  logic [14:0] data,
    input  logic [1:0]  mode,
    input  logic        on,
    input  logic        isGBC,
    input  logic        blend_en,
    output logic        clkena_out,
    output logic [14:0] data_out,
    output logic [1:0]  mode_out,
    output logic        on_out
);

    localparam int unsigned NPIX    = 23040;
    localparam logic [14:0] PTR_MAX = 15'd23040;

    // Frame position and previous-frame validity
    logic [14:0] wr_ptr_q, wr_ptr_d;
    logic        prev_valid_q, prev_valid_d;
    logic        vblank_q;
    logic        gbc_q;

    logic vblank;
    logic ptr_clear;
    logic capture;

    assign vblank    = (mode == 2'd1);
    assign ptr_clear = !on || vblank;
    assign capture   = clkena && !ptr_clear && (wr_ptr_q < PTR_MAX);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (ptr_clear) begin
            wr_ptr_d = '0;
        end else if (capture) begin
            wr_ptr_d = wr_ptr_q + 15'd1;
        end
    end

    // A frame counts as usable only if it reached the last pixel before vblank began.
    always_comb begin
        prev_valid_d = prev_valid_q;
        if (!on) begin
            prev_valid_d = 1'b0;
        end else if (isGBC != gbc_q) begin
            prev_valid_d = 1'b0;
        end else if (vblank && !vblank_q) begin
            prev_valid_d = (wr_ptr_q == PTR_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            prev_valid_q <= 1'b0;
            vblank_q     <= 1'b0;
            gbc_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            prev_valid_q <= prev_valid_d;
            vblank_q     <= vblank;
            gbc_q        <= isGBC;
        end
    end

    // Stage 0 -> stage 1 registers
    logic        s1_valid_q;
    logic        s1_write_q;
    logic        s1_blend_q;
    logic        s1_gbc_q;
    logic [14:0] s1_data_q;
    logic [14:0] s1_addr_q;
    logic [1:0]  s1_mode_q;
    logic        s1_on_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_write_q <= 1'b0;
            s1_blend_q <= 1'b0;
            s1_gbc_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_addr_q  <= '0;
            s1_mode_q  <= '0;
            s1_on_q    <= 1'b0;
        end else begin
            s1_valid_q <= clkena;
            s1_write_q <= capture;
            s1_blend_q <= capture && blend_en && prev_valid_q;
            s1_gbc_q   <= isGBC;
            s1_data_q  <= data;
            s1_addr_q  <= wr_ptr_q;
            s1_mode_q  <= mode;
            s1_on_q    <= on;
        end
    end

    // Frame store: contents survive reset, reads are registered for block RAM inference.
    logic [14:0] mem [0:NPIX-1];
    logic [14:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (capture) begin
            ram_rd_q <= mem[wr_ptr_q];
        end
        if (s1_write_q) begin
            mem[s1_addr_q] <= s1_data_q;
        end
    end

    // Round-half-up averages of previous (ram_rd_q) and current (s1_data_q) pixels
    logic [14:0] gbc_mix;
    logic [14:0] dmg_mix;
    logic [14:0] pix_d;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign gbc_mix[gi*5 +: 5] =
                5'((6'(ram_rd_q[gi*5 +: 5]) + 6'(s1_data_q[gi*5 +: 5]) + 6'd1) >> 1);
        end
    endgenerate

    assign dmg_mix = {13'd0, 2'((3'(ram_rd_q[1:0]) + 3'(s1_data_q[1:0]) + 3'd1) >> 1)};

    always_comb begin
        pix_d = s1_data_q;
        if (s1_blend_q) begin
            pix_d = s1_gbc_q ? gbc_mix : dmg_mix;
        end
    end

    // Stage 1 output registers; data_out holds its last pixel between strobes.
    logic        clkena_out_q;
    logic [14:0] data_out_q;
    logic [1:0]  mode_out_q;
    logic        on_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clkena_out_q <= 1'b0;
            data_out_q   <= '0;
            mode_out_q   <= '0;
            on_out_q     <= 1'b0;
        end else begin
            clkena_out_q <= s1_valid_q;
            mode_out_q   <= s1_mode_q;
            on_out_q     <= s1_on_q;
            if (s1_valid_q) begin
                data_out_q <= pix_d;
            end
        end
    end

    assign clkena_out = clkena_out_q;
    assign data_out   = data_out_q;
    assign mode_out   = mode_out_q;
    assign on_out     = on_out_q;

endmodule

// File: tb/tb_lcd_ghost_blend.sv
// Bench for lcd_ghost_blend: a frame-store model predicts every output cycle,
// and literal per-frame expectations pin the model itself.
module tb_lcd_ghost_blend;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkena;
    logic [14:0] data;
    logic [1:0]  mode;
    logic        on;
    logic        isGBC;
    logic        blend_en;
    logic        clkena_out;
    logic [14:0] data_out;
    logic [1:0]  mode_out;
    logic        on_out;

    always #5 clk = ~clk;

    lcd_ghost_blend dut (
        .clk        (clk),
        .reset      (reset),
        .clkena     (clkena),
        .data       (data),
        .mode       (mode),
        .on         (on),
        .isGBC      (isGBC),
        .blend_en   (blend_en),
        .clkena_out (clkena_out),
        .data_out   (data_out),
        .mode_out   (mode_out),
        .on_out     (on_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic        chk_d;
        logic [14:0] d;
        logic [1:0]  m;
        logic        o;
    } exp_t;

    exp_t expq[$];

    // Model state: last raw pixel per frame position, position counter, validity of previous frame
    logic [14:0] store_m [0:23039];
    int          ptr_m;
    bit          pv_m;
    bit          last_vb_m;
    bit          last_gbc_m;

    int          out_count;
    logic [14:0] out_hist [0:23099];

    function automatic logic [14:0] mix(input logic [14:0] p, input logic [14:0] c, input bit gbc);
        int          s;
        logic [14:0] r;
        r = '0;
        if (gbc) begin
            for (int ch = 0; ch < 3; ch++) begin
                s = (int'(p[ch*5 +: 5]) + int'(c[ch*5 +: 5]) + 1) / 2;
                r[ch*5 +: 5] = s[4:0];
            end
        end else begin
            s = (int'(p[1:0]) + int'(c[1:0]) + 1) / 2;
            r[1:0] = s[1:0];
        end
        return r;
    endfunction

    // Model: one expectation per clock edge, describing the outputs one edge later.
    initial begin : model
        exp_t e;
        bit   vb;
        bit   cap;
        forever begin
            @(posedge clk);
            if (reset) begin
                expq.delete();
                e = '{v: 1'b0, chk_d: 1'b1, d: 15'd0, m: 2'd0, o: 1'b0};
                expq.push_back(e);
                expq.push_back(e);
                ptr_m      = 0;
                pv_m       = 0;
                last_vb_m  = 0;
                last_gbc_m = isGBC;
            end else begin
                vb      = (mode == 2'd1);
                cap     = clkena && on && !vb && (ptr_m < 23040);
                e.v     = clkena;
                e.chk_d = clkena;
                e.m     = mode;
                e.o     = on;
                e.d     = (cap && blend_en && pv_m) ? mix(store_m[ptr_m], data, isGBC) : data;
                if (cap) store_m[ptr_m] = data;
                if (!on) pv_m = 0;
                else if (isGBC != last_gbc_m) pv_m = 0;
                else if (vb && !last_vb_m) pv_m = (ptr_m == 23040);
                if (!on || vb) ptr_m = 0;
                else if (cap) ptr_m++;
                last_vb_m  = vb;
                last_gbc_m = isGBC;
                expq.push_back(e);
            end
        end
    end

    // Compare process: checks DUT outputs against the model on every cycle.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() >= 2) begin
                e = expq.pop_front();
                checks++;
                if (clkena_out !== e.v) begin
                    errors++;
                    if (errors < 30) $display("FAIL clkena_out t=%0t got %b want %b", $time, clkena_out, e.v);
                end
                if (e.chk_d) begin
                    checks++;
                    if (data_out !== e.d) begin
                        errors++;
                        if (errors < 30) $display("FAIL data_out t=%0t got %h want %h", $time, data_out, e.d);
                    end
                end
                checks++;
                if (mode_out !== e.m || on_out !== e.o) begin
                    errors++;
                    if (errors < 30) $display("FAIL mode/on_out t=%0t got %0d/%b want %0d/%b",
                                              $time, mode_out, on_out, e.m, e.o);
                end
            end
            if (clkena_out === 1'b1) begin
                if (out_count < 23100) out_hist[out_count] = data_out;
                out_count++;
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step(input bit s, input logic [14:0] d, input logic [1:0] m);
        @(posedge clk);
        #2;
        clkena = s;
        data   = d;
        mode   = m;
    endtask

    task automatic frame(input int n, input logic [14:0] d, input logic [14:0] tail, input int gap);
        out_count = 0;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && (i % gap) == gap - 1) step(1'b0, 15'd0, 2'd3);
            step(1'b1, (i >= 23040) ? tail : d, 2'd3);
        end
        step(1'b0, 15'd0, 2'd3);
    endtask

    task automatic vblank_period();
        repeat (6) step(1'b0, 15'd0, 2'd1);
        repeat (4) step(1'b0, 15'd0, 2'd2);
    endtask

    task automatic report(input string nm);
        $display("frame %s: %0d pixels out, first %h", nm, out_count, out_hist[0]);
    endtask

    initial begin
        reset = 1'b1; clkena = 1'b0; data = '0; mode = 2'd0;
        on = 1'b1; isGBC = 1'b0; blend_en = 1'b1;
        out_count = 0;
        repeat (3) @(posedge clk);
        #2;
        lit("reset_outputs", {15'd0, clkena_out, data_out, mode_out, on_out}, 32'd0);
        reset = 1'b0;
        repeat (3) step(1'b0, 15'd0, 2'd0);

        // DMG shade 3, strobes with gaps: no previous frame, pass-through
        frame(23040, 15'd3, 15'd3, 8);
        vblank_period();
        report("dmg3");
        lit("f1_count", out_count, 23040);
        lit("f1_first", {17'd0, out_hist[0]}, 32'd3);
        lit("f1_last", {17'd0, out_hist[23039]}, 32'd3);

        // DMG shade 0 blended with 3 -> 2; five surplus strobes of shade 3 pass raw
        frame(23045, 15'd0, 15'd3, 0);
        vblank_period();
        report("dmg0_sat");
        lit("f2_count", out_count, 23045);
        lit("f2_first", {17'd0, out_hist[0]}, 32'd2);
        lit("f2_addr23039", {17'd0, out_hist[23039]}, 32'd2);
        lit("f2_sat_first", {17'd0, out_hist[23040]}, 32'd3);
        lit("f2_sat_last", {17'd0, out_hist[23044]}, 32'd3);

        // Shade 2 over stored 0 -> 1; shows the surplus pixels were not stored. Cut short.
        frame(100, 15'd2, 15'd2, 0);
        vblank_period();
        report("dmg2_short");
        lit("f3_first", {17'd0, out_hist[0]}, 32'd1);
        lit("f3_addr4", {17'd0, out_hist[4]}, 32'd1);
        lit("f3_last", {17'd0, out_hist[99]}, 32'd1);

        // After a short frame: pass-through (blending would give 1)
        frame(50, 15'd0, 15'd0, 0);
        vblank_period();
        report("dmg_pass");
        lit("f4_first", {17'd0, out_hist[0]}, 32'd0);
        lit("f4_count", out_count, 50);

        on = 1'b0;
        repeat (3) step(1'b0, 15'd0, 2'd0);
        on = 1'b1;
        isGBC = 1'b1;
        repeat (3) step(1'b0, 15'd0, 2'd0);

        // GBC r=31 g=0 b=10, back-to-back strobes
        frame(23040, 15'h281F, 15'h281F, 0);
        vblank_period();
        report("gbc_a");
        lit("f5_count", out_count, 23040);
        lit("f5_first", {17'd0, out_hist[0]}, 32'h281F);

        // GBC r=0 g=31 b=11 -> {b=11,g=16,r=16}; reset lands mid-burst
        out_count = 0;
        for (int i = 0; i < 200; i++) step(1'b1, 15'h2FE0, 2'd3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        lit("midreset_clkena_out", {31'd0, clkena_out}, 32'd0);
        lit("midreset_data_out", {17'd0, data_out}, 32'd0);
        report("gbc_b");
        lit("f6_first", {17'd0, out_hist[0]}, 32'h2E10);
        lit("f6_mid", {17'd0, out_hist[150]}, 32'h2E10);
        reset  = 1'b0;
        clkena = 1'b0;
        frame(100, 15'h7FFF, 15'h7FFF, 0);
        vblank_period();
        report("gbc_after_reset");
        lit("f6b_count", out_count, 100);
        lit("f6b_first", {17'd0, out_hist[0]}, 32'h7FFF);

        // Frame after the interrupted one: pass-through even with blend_en=1
        frame(60, 15'h0000, 15'h0000, 0);
        vblank_period();
        report("gbc_pass");
        lit("f7_count", out_count, 60);
        lit("f7_first", {17'd0, out_hist[0]}, 32'h0000);
        lit("f7_last", {17'd0, out_hist[59]}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
